regfile_exec_unit: RTL and testbench
====================================

# regfile_exec_unit

Multi-cycle execute/writeback sequencer that sits directly beside the 32x32 register file (`REGISTERS`). It drives both register-file read ports and owns its single write port. It accepts one register-to-register command at a time over a valid/ready handshake, reads the two source operands and computes the result. Integer multiply is iterative. It then writes the result back through the write port and pulses `done`.

## Interface
- `DATA_W`, 32, operand/result width (fixed to 32 for the register file).
- `ADDR_W`, 5, register address width.
- `clk`  in  1  system clock, rising-edge.
- `clr`  in  1  reset, asynchronous, active-high; shared with the register file.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  unit can accept a command.
- `cmd_op`  in  4  operation code (see Operation).
- `cmd_rs1`, `cmd_rs2`  in  5 each  source register addresses.
- `cmd_rd`  in  5  destination register address.
- `cmd_imm`  in  32  immediate, used by LI only.
- `readaddr1`, `readaddr2`  out  5 each  to register-file read ports.
- `read1`, `read2`  in  32 each  register-file read data (combinational).
- `writeaddr`  out  5  to register-file write address.
- `write_data`  out  32  to register-file write data.
- `write_cntrl`  out  1  write enable; the register file commits on the rising edge of `clk`.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  single-cycle completion pulse.

## Operation
- Opcodes (all arithmetic is modulo 2^32):
  - 0000 ADD: rs1+rs2.
  - 0001 SUB: rs1−rs2.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL: rs1 << rs2[4:0].
  - 0110 SRL: logical rs1 >> rs2[4:0].
  - 0111 MUL: low 32 bits of rs1*rs2, shift-add, one bit per cycle.
  - 1000 LI: rd ← cmd_imm.
  - 1001–1111 reserved: no write, `done` still pulses.
- States:
  - IDLE → READ on the edge where `cmd_valid && cmd_ready`. At that edge, op/rs1/rs2/rd/imm are latched and `readaddr1/2` are registered to rs1/rs2.
  - READ → EXEC. `read1`/`read2` are captured into operand registers at the end of READ.
  - EXEC → WB after 1 cycle for non-MUL ops. For MUL, EXEC lasts exactly 32 cycles, driven by a 5-bit down-counter; multiplier bit 0 is examined each cycle.
  - WB → IDLE.
- In WB, `writeaddr`=rd, `write_data`=result, `write_cntrl`=1 for exactly one cycle, and `done`=1 for that cycle.
- rd=0 or a reserved op: `write_cntrl` stays 0 in WB. `done` still pulses.
- `cmd_ready` = (state==IDLE) and `clr` low. `cmd_valid` in any other state is ignored; no queuing.
- `readaddr1/2` hold their values from accept until the next accept.
- `write_data`/`writeaddr` are don't-care when `write_cntrl`=0, but are driven to 0 in IDLE.
- rs1==rs2, rs==rd and back-to-back dependent commands are legal. Only one command is in flight, so there is no hazard: the next command's READ happens after the previous write committed.

## Timing
- Reset (async on `clr` high, held while high):
  - state=IDLE; operand, result and counter registers = 0.
  - `readaddr1/2`=0, `writeaddr`=0, `write_data`=0, `write_cntrl`=0, `busy`=0, `done`=0.
  - `cmd_ready`=1 once `clr` deasserts.
- Latency, with accept edge = E0:
  - Non-MUL: READ in cycle 1, EXEC in cycle 2, WB in cycle 3. The register is updated at edge E3. `cmd_ready` returns high in cycle 4.
  - MUL: READ in cycle 1, EXEC in cycles 2–33, WB in cycle 34. The register is updated at E34.
- Back-to-back throughput: one command per 4 cycles for non-MUL, one per 35 cycles for MUL.
- Reset mid-operation, in any state including WB before the edge: the command is aborted, `write_cntrl` drops immediately, no register write occurs, and `done` is not pulsed.

## Test plan
- `clr` pulse, then LI rd=25 imm=25, then LI rd=28 imm=28 → each WB shows writeaddr 25/28, write_data 25/28, and write_cntrl high exactly 3 cycles after accept. `cmd_ready` is low for cycles 1–3.
- ADD rs1=28 rs2=25 rd=16 → WB write_data=53, writeaddr=16. A following ADD rs1=16 rs2=16 rd=17 → 106, which checks back-to-back dependency.
- SUB rs1=25 rs2=28 rd=1 → 0xFFFFFFFD. SLL rs1=25 rs2=28 → 25<<28 = 0x90000000. SRL of 0x90000000 by 28 → 9.
- MUL rs1=25 rs2=28 rd=2 → write_data=700 with `done` at cycle 34. MUL 0xFFFFFFFF*0xFFFFFFFF → 1. `cmd_valid` pulsed during EXEC → not accepted, no extra `done`.
- LI rd=0 imm=5 and opcode 1111 → `done` pulses, `write_cntrl` never asserts.
- `clr` asserted in MUL EXEC cycle 10 → `busy`=0 and `write_cntrl`=0 immediately, no `done`. After release, `cmd_ready`=1 and a register read via ADD r25+r0 writes 0, confirming the register file was cleared.

Source files
------------

// File: rtl/regfile_exec_unit.sv
// Execute/writeback sequencer beside a 32x32 register file: reads two sources,
// computes one result (iterative shift-add multiply), writes it back and pulses done.
module regfile_exec_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_rs1_i,
  input  logic [ADDR_W-1:0] cmd_rs2_i,
  input  logic [ADDR_W-1:0] cmd_rd_i,
  input  logic [DATA_W-1:0] cmd_imm_i,
  output logic [ADDR_W-1:0] readaddr1_o,
  output logic [ADDR_W-1:0] readaddr2_o,
  input  logic [DATA_W-1:0] read1_i,
  input  logic [DATA_W-1:0] read2_i,
  output logic [ADDR_W-1:0] writeaddr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              write_cntrl_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam logic [3:0] OP_LI  = 4'h8;

  state_t              state_q;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   opa_q, opb_q, res_q;
  logic [4:0]          cnt_q;
  logic [ADDR_W-1:0]   readaddr1_q, readaddr2_q, writeaddr_q;
  logic [DATA_W-1:0]   write_data_q;
  logic                write_cntrl_q, done_q;

  logic [DATA_W-1:0]   mul_sum_d, alu_d;
  logic                wr_en_d;

  // Multiply: opa_q shifts left, opb_q shifts right, its bit 0 gates the add.
  always_comb begin
    mul_sum_d = opb_q[0] ? (res_q + opa_q) : res_q;
    unique case (op_q)
      OP_ADD:  alu_d = opa_q + opb_q;
      OP_SUB:  alu_d = opa_q - opb_q;
      OP_AND:  alu_d = opa_q & opb_q;
      OP_OR:   alu_d = opa_q | opb_q;
      OP_XOR:  alu_d = opa_q ^ opb_q;
      OP_SLL:  alu_d = opa_q << opb_q[4:0];
      OP_SRL:  alu_d = opa_q >> opb_q[4:0];
      OP_MUL:  alu_d = mul_sum_d;
      OP_LI:   alu_d = imm_q;
      default: alu_d = '0;
    endcase
    wr_en_d = (rd_q != '0) && (op_q <= OP_LI);
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      readaddr1_q   <= '0;
      readaddr2_q   <= '0;
      writeaddr_q   <= '0;
      write_data_q  <= '0;
      write_cntrl_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      write_cntrl_q <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q        <= cmd_op_i;
            rd_q        <= cmd_rd_i;
            imm_q       <= cmd_imm_i;
            readaddr1_q <= cmd_rs1_i;
            readaddr2_q <= cmd_rs2_i;
            state_q     <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= read1_i;
          opb_q   <= read2_i;
          res_q   <= '0;
          cnt_q   <= 5'd31;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // Final multiply step folds into the WB setup, giving 32 EXEC cycles.
          if ((op_q == OP_MUL) && (cnt_q != 5'd0)) begin
            res_q <= mul_sum_d;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
            cnt_q <= cnt_q - 5'd1;
          end else begin
            res_q         <= alu_d;
            writeaddr_q   <= rd_q;
            write_data_q  <= alu_d;
            write_cntrl_q <= wr_en_d;
            done_q        <= 1'b1;
            state_q       <= S_WB;
          end
        end
        S_WB: begin
          writeaddr_q  <= '0;
          write_data_q <= '0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE) && !clr_i;
  assign busy_o        = (state_q != S_IDLE);
  assign readaddr1_o   = readaddr1_q;
  assign readaddr2_o   = readaddr2_q;
  assign writeaddr_o   = writeaddr_q;
  assign write_data_o  = write_data_q;
  assign write_cntrl_o = write_cntrl_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Bench for regfile_exec_unit: behavioural register file, directed commands,
// expected writebacks queued at issue and checked by a done-triggered monitor.
module tb_regfile_exec_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic [31:0] cmd_imm = '0;
  logic [4:0]  readaddr1, readaddr2, writeaddr;
  logic [31:0] read1, read2, write_data;
  logic        write_cntrl, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  regfile_exec_unit dut (
    .clk_i(clk), .clr_i(clr), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_rd_i(cmd_rd),
    .cmd_imm_i(cmd_imm), .readaddr1_o(readaddr1), .readaddr2_o(readaddr2),
    .read1_i(read1), .read2_i(read2), .writeaddr_o(writeaddr),
    .write_data_o(write_data), .write_cntrl_o(write_cntrl), .busy_o(busy), .done_o(done)
  );

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_cntrl) begin
      regs[writeaddr] <= write_data;
    end
  end
  assign read1 = regs[readaddr1];
  assign read2 = regs[readaddr2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (done) begin
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion pending");
        end else begin
          e = sb_q.pop_front();
          check("wb_write_cntrl", {31'd0, write_cntrl}, {31'd0, e.wc});
          if (e.wc) begin
            check("wb_writeaddr", {27'd0, writeaddr}, {27'd0, e.addr});
            check("wb_write_data", write_data, e.data);
          end
        end
      end else if (write_cntrl) begin
        checks++;
        errors++;
        $display("FAIL write_without_done: got write_cntrl=1 expected 0");
      end
    end
  end

  // Called right after a falling edge; returns right after the falling edge of
  // the first cycle in which cmd_ready is expected back.
  task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic exp_wc,
                       input logic [31:0] exp_data, input int exp_lat, input bit poke);
    int  lat;
    bit  rdy_low;
    exp_t e;
    lat = 0;
    rdy_low = 1'b1;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
    check("ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    e.wc = exp_wc; e.addr = rd; e.data = exp_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cmd_ready) rdy_low = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (poke && k == 10) begin
        cmd_op = 4'h0; cmd_rs1 = 5'd1; cmd_rs2 = 5'd1; cmd_rd = 5'd20;
        cmd_valid = 1'b1;
      end
      if (poke && k == 11) cmd_valid = 1'b0;
    end
    check("done_latency", lat, exp_lat);
    check("ready_low_while_busy", {31'd0, rdy_low}, 32'd1);
    @(negedge clk);
    check("ready_after_wb", {31'd0, cmd_ready}, 32'd1);
    check("readaddr1_hold", {27'd0, readaddr1}, {27'd0, rs1});
    check("readaddr2_hold", {27'd0, readaddr2}, {27'd0, rs2});
  endtask

  // Accepts a command and asserts clr partway through cycle `cyc` after accept.
  task automatic abort(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input int cyc);
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (cyc - 1) @(posedge clk);
    #1 check("abort_busy_before", {31'd0, busy}, 32'd1);
    #1 clr = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_write_cntrl", {31'd0, write_cntrl}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1 check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_write_cntrl", {31'd0, write_cntrl}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_writeaddr", {27'd0, writeaddr}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_readaddr1", {27'd0, readaddr1}, 32'd0);
    clr = 1'b0;
    #1 check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    issue(4'h8, 5'd0,  5'd0,  5'd25, 32'd25,       1'b1, 32'd25,         3,  1'b0);
    issue(4'h8, 5'd0,  5'd0,  5'd28, 32'd28,       1'b1, 32'd28,         3,  1'b0);
    issue(4'h0, 5'd28, 5'd25, 5'd16, 32'd0,        1'b1, 32'd53,         3,  1'b0);
    issue(4'h0, 5'd16, 5'd16, 5'd17, 32'd0,        1'b1, 32'd106,        3,  1'b0);
    issue(4'h1, 5'd25, 5'd28, 5'd1,  32'd0,        1'b1, 32'hFFFF_FFFD,  3,  1'b0);
    issue(4'h5, 5'd25, 5'd28, 5'd3,  32'd0,        1'b1, 32'h9000_0000,  3,  1'b0);
    issue(4'h6, 5'd3,  5'd28, 5'd4,  32'd0,        1'b1, 32'd9,          3,  1'b0);
    issue(4'h2, 5'd25, 5'd28, 5'd5,  32'd0,        1'b1, 32'd24,         3,  1'b0);
    issue(4'h3, 5'd25, 5'd28, 5'd6,  32'd0,        1'b1, 32'd29,         3,  1'b0);
    issue(4'h4, 5'd25, 5'd28, 5'd7,  32'd0,        1'b1, 32'd5,          3,  1'b0);
    issue(4'h7, 5'd25, 5'd28, 5'd2,  32'd0,        1'b1, 32'd700,        34, 1'b1);
    issue(4'h8, 5'd0,  5'd0,  5'd8,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 3,  1'b0);
    issue(4'h7, 5'd8,  5'd8,  5'd9,  32'd0,        1'b1, 32'd1,          34, 1'b0);
    issue(4'h8, 5'd0,  5'd0,  5'd0,  32'd5,        1'b0, 32'd0,          3,  1'b0);
    issue(4'hF, 5'd25, 5'd28, 5'd10, 32'd0,        1'b0, 32'd0,          3,  1'b0);
    issue(4'h0, 5'd10, 5'd0,  5'd11, 32'd0,        1'b1, 32'd0,          3,  1'b0);
    issue(4'h0, 5'd2,  5'd9,  5'd12, 32'd0,        1'b1, 32'd701,        3,  1'b0);

    abort(4'h8, 5'd0, 5'd0, 5'd13, 32'd77, 3);
    issue(4'h0, 5'd25, 5'd0, 5'd14, 32'd0,         1'b1, 32'd0,          3,  1'b0);
    issue(4'h8, 5'd0,  5'd0, 5'd25, 32'd25,        1'b1, 32'd25,         3,  1'b0);
    issue(4'h8, 5'd0,  5'd0, 5'd28, 32'd28,        1'b1, 32'd28,         3,  1'b0);
    abort(4'h7, 5'd25, 5'd28, 5'd2, 32'd0, 10);
    issue(4'h0, 5'd25, 5'd0, 5'd15, 32'd0,         1'b1, 32'd0,          3,  1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
